instr_cache_2way: RTL

- Parametrised two-way set-associative instruction cache between the CPU fetch stage and the instruction ROM.
- Successor to the single-word cache. Adds multi-word lines, configurable geometry, an LRU victim policy, a req/valid handshake to a variable-latency ROM, critical-word return and a flush input.
- Addresses are word addresses throughout.

---
 rtl/instr_cache_2way_if.sv | 26 ++
 rtl/instr_cache_2way.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_2way_if.sv
// Bus bundle for instr_cache_2way: CPU fetch handshake, flush and ROM refill port.
// The cache takes the slave modport; the fetch stage / ROM side take the master modport.
interface instr_cache_2way_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              flush;
    logic [DATA_W-1:0] instruction_out;
    logic              instruction_ready;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_valid;
    logic [DATA_W-1:0] rom_result;

    modport slave (
        input  req, addr, flush, rom_valid, rom_result,
        output instruction_out, instruction_ready, rom_req, rom_addr
    );

    modport master (
        output req, addr, flush, rom_valid, rom_result,
        input  instruction_out, instruction_ready, rom_req, rom_addr
    );
endinterface

// File: rtl/instr_cache_2way.sv
// Two-way set-associative instruction cache with LRU victims, multi-word line refill and flush.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instr_cache_2way #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 2,
    parameter int OFFSET_W = 2
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    instr_cache_2way_if.slave    bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t                   state_q;
    logic [1:0][SETS-1:0]     valid_q;
    logic [SETS-1:0]          lru_q;
    logic [DATA_W-1:0]        out_q;
    logic                     ready_q;
    logic                     rom_req_q;
    logic [ADDR_W-1:0]        rom_addr_q;
    logic                     flush_pend_q;
    logic [OFFSET_W-1:0]      cnt_q;
    logic                     victim_q;
    logic [TAG_W-1:0]         miss_tag_q;
    logic [INDEX_W-1:0]       miss_idx_q;
    logic [OFFSET_W-1:0]      miss_off_q;
    logic [DATA_W-1:0]        resp_word_q;
`ifdef ICACHE_STATS_EN
    logic [31:0]              hit_count_q;
    logic [31:0]              miss_count_q;
`endif

    logic [TAG_W-1:0]         req_tag;
    logic [INDEX_W-1:0]       req_idx;
    logic [OFFSET_W-1:0]      req_off;
    logic [1:0]               way_hit;
    logic [1:0][DATA_W-1:0]   rd_word;
    logic                     victim_d;
    logic [OFFSET_W-1:0]      cnt_d;
    logic                     fill_we;
    logic                     fill_last;
    logic                     off_match;

    assign {req_tag, req_idx, req_off} = bus.addr;

    assign cnt_d     = cnt_q + OFFSET_W'(1);
    assign fill_we   = (state_q == S_REFILL) && bus.rom_valid && !iRST;
    assign fill_last = &cnt_q;
    assign off_match = (cnt_q == miss_off_q);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            logic [DATA_W-1:0] data_mem [SETS*WORDS];
            logic [TAG_W-1:0]  tag_mem  [SETS];

            always_ff @(posedge iCLK) begin
                if (fill_we && (victim_q == 1'(gi))) begin
                    data_mem[{miss_idx_q, cnt_q}] <= bus.rom_result;
                    if (fill_last) begin
                        tag_mem[miss_idx_q] <= miss_tag_q;
                    end
                end
            end

            assign rd_word[gi] = data_mem[{req_idx, req_off}];
            assign way_hit[gi] = valid_q[gi][req_idx] && (tag_mem[req_idx] == req_tag);
        end
    endgenerate

    // Invalid ways are filled first (way0 before way1); otherwise evict the LRU way.
    always_comb begin
        victim_d = lru_q[req_idx];
        if (!valid_q[0][req_idx]) begin
            victim_d = 1'b0;
        end else if (!valid_q[1][req_idx]) begin
            victim_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            lru_q        <= '0;
            out_q        <= '0;
            ready_q      <= 1'b0;
            rom_req_q    <= 1'b0;
            rom_addr_q   <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            victim_q     <= 1'b0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            miss_off_q   <= '0;
            resp_word_q  <= '0;
`ifdef ICACHE_STATS_EN
            hit_count_q  <= '0;
            miss_count_q <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.flush) begin
                        state_q <= S_FLUSH;
                    end else if (bus.req && !ready_q) begin
                        if (|way_hit) begin
                            ready_q        <= 1'b1;
                            out_q          <= way_hit[0] ? rd_word[0] : rd_word[1];
                            lru_q[req_idx] <= way_hit[0];
`ifdef ICACHE_STATS_EN
                            if (hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
`endif
                        end else begin
                            miss_tag_q                 <= req_tag;
                            miss_idx_q                 <= req_idx;
                            miss_off_q                 <= req_off;
                            victim_q                   <= victim_d;
                            valid_q[victim_d][req_idx] <= 1'b0;
                            cnt_q                      <= '0;
                            rom_req_q                  <= 1'b1;
                            rom_addr_q                 <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                            state_q                    <= S_REFILL;
`ifdef ICACHE_STATS_EN
                            if (miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
`endif
                        end
                    end
                end
                S_REFILL: begin
                    if (bus.flush) flush_pend_q <= 1'b1;
                    if (bus.rom_valid) begin
                        if (off_match) resp_word_q <= bus.rom_result;
                        if (fill_last) begin
                            valid_q[victim_q][miss_idx_q] <= 1'b1;
                            rom_req_q <= 1'b0;
                            ready_q   <= 1'b1;
                            out_q     <= off_match ? bus.rom_result : resp_word_q;
                            state_q   <= S_RESP;
                        end else begin
                            cnt_q      <= cnt_d;
                            rom_addr_q <= {miss_tag_q, miss_idx_q, cnt_d};
                        end
                    end
                end
                S_RESP: begin
                    lru_q[miss_idx_q] <= ~victim_q;
                    state_q <= (flush_pend_q || bus.flush) ? S_FLUSH : S_IDLE;
                end
                S_FLUSH: begin
                    valid_q      <= '0;
                    lru_q        <= '0;
                    flush_pend_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instruction_out   = out_q;
    assign bus.instruction_ready = ready_q;
    assign bus.rom_req           = rom_req_q;
    assign bus.rom_addr          = rom_addr_q;
`ifdef ICACHE_STATS_EN
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule
